mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Sequences a byte-wide, single-ported data memory (combinational read, write on clock edge) through multi-cycle word, half and byte accesses.
- Arbitrates the memory between two requesters: instruction fetch (word reads only) and the load/store unit (reads and writes of any supported size).
- Assembles little-endian read data and applies sign/zero extension.
- Sits between the core's fetch/LSU and the byte memory array.

Parameters:
- MEM_BYTES, 16, memory size in bytes; any access touching a byte at address >= MEM_BYTES is a range error.
- ADDR_W, 32, width of all address ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle completion pulse for the fetch.
- if_rdata  out  32  fetched word; valid while if_ack=1.
- if_err  out  1  range error; valid while if_ack=1.
- d_req  in  1  data request; held high, with all d_* inputs stable, until d_ack.
- d_we  in  1  1=store, 0=load.
- d_size  in  3  3'b100=word, 3'b010=half, 3'b001=byte.
- d_unsigned  in  1  1=zero-extend load, 0=sign-extend load.
- d_addr  in  ADDR_W  data byte address; misaligned addresses are allowed.
- d_wdata  in  32  store data; low bytes are used.
- d_ack  out  1  one-cycle completion pulse for the data request.
- d_rdata  out  32  extended load data; valid while d_ack=1.
- d_err  out  1  range or size error; valid while d_ack=1.
- m_addr  out  ADDR_W  memory byte address.
- m_re  out  1  read beat.
- m_we  out  1  write beat.
- m_wdata  out  8  write byte.
- m_rdata  in  8  read byte, combinational from m_addr.
- busy  out  1  high in XFER and RESP.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, grant-history bit = fetch, internal buffers 0.
- Reset asserted mid-transfer aborts the access immediately. Bytes already written stay written. No ack is issued.
- FSM states:
  - IDLE: if any request is pending, latch owner, address, size (fetch forces word), we, wdata and unsigned. Then check the request:
    - Range error if addr + nbytes - 1 >= MEM_BYTES, computed at ADDR_W+1 bits so a 32-bit wrap counts as an error.
    - Size error (data port only) if d_size is not one of the three encodings.
    - On error go to RESP with err=1. Otherwise go to XFER with beat=0.
  - XFER: one byte per cycle, with m_addr = base + beat.
    - Read: m_re=1; m_rdata is captured into buffer byte [beat] at the clock edge.
    - Write: m_we=1; m_wdata = wdata byte [beat].
    - When beat == nbytes-1, go to RESP; otherwise increment beat.
  - RESP: the owner's ack=1 for exactly one cycle with registered rdata/err; then go to IDLE.
    - Load data: half is {16 x ext, b1, b0}; byte is {24 x ext, b0}; ext = 0 if unsigned, else the top loaded bit.
    - Writes and errors return rdata=0.
- Arbitration, evaluated only in IDLE:
  - Only one requester pending: it wins.
  - Both pending: data wins unless the previous grant went to data, in which case fetch wins (alternation).
  - The grant-history bit updates on every grant.
- Latency from req sampled in IDLE to ack: 1 + nbytes + 1 cycles. Word = 6, half = 4, byte = 3, error = 2.
- The requester drops req at the edge ending its ack cycle. A req still high in IDLE is a new request.
- Outside XFER: m_re=m_we=0, m_wdata=0, m_addr=0.
- m_re and m_we are never high together.
- Only the owner's ack/rdata/err change; the other port's outputs read 0.

Test Plan:
- Store word 0xA1B2C3D4 at d_addr=4, size=100 -> m_we on 4 cycles at addr 4..7 with bytes D4, C3, B2, A1; d_ack 6 cycles after request; d_err=0.
- Load half at addr 6, signed, then unsigned, with mem[6]=B2, mem[7]=A1 -> d_rdata=0xFFFFA1B2, then 0x0000A1B2. Signed load byte at addr 4 (mem=D4) -> 0xFFFFFFD4.
- Fetch word at addr 0 with mem[0..3]=04,03,02,05 -> if_rdata=0x05020304, if_ack exactly 6 cycles after if_req.
- if_req and d_req raised in the same cycle, both held and re-requested after each ack -> grant order data, fetch, data, fetch; no overlapping beats.
- d_addr=14 with size=100, MEM_BYTES=16 -> d_err=1, d_rdata=0, no m_we, ack in 2 cycles. d_size=3'b011 -> d_err=1.
- rst=0 during beat 2 of a word store -> outputs 0 immediately, bytes 0-1 written, byte 2 not, no d_ack; after release, a new request completes normally.

Source files
------------

// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if: fetch, load/store and byte-memory signals of the access sequencer
interface mem_access_sequencer_if #(parameter int ADDR_W = 32);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              if_err;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_size;
    logic              d_unsigned;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic [ADDR_W-1:0] m_addr;
    logic              m_re;
    logic              m_we;
    logic [7:0]        m_wdata;
    logic [7:0]        m_rdata;
    logic              busy;
    modport master (
        input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, m_rdata,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, m_addr, m_re, m_we, m_wdata, busy
    );
    modport slave (
        output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, m_rdata,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, m_addr, m_re, m_we, m_wdata, busy
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: arbitrates fetch and load/store onto a byte-wide memory,
// one byte per cycle, with little-endian assembly and sign/zero extension.
module mem_access_sequencer #(
    parameter int MEM_BYTES = 16,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    mem_access_sequencer_if.master bus_io
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;
    state_e            state_q;
    logic              owner_q, hist_q, we_q, uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        nb_q;
    logic [1:0]        beat_q;
    logic [31:0]       wdata_q, buf_q;
    logic              if_ack_q, if_err_q, d_ack_q, d_err_q;
    logic [31:0]       if_rdata_q, d_rdata_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic              m_re_q, m_we_q;
    logic [7:0]        m_wdata_q;
    logic              gnt_d, wr_d, size_ok_d, err_d, ext_d, last_beat_d;
    logic [ADDR_W-1:0] addr_d;
    logic [2:0]        nb_d;
    logic [ADDR_W:0]   last_d;
    logic [31:0]       buf_d, rdata_d;
    logic [1:0]        beat_d;
    assign bus_io.if_ack   = if_ack_q;
    assign bus_io.if_err   = if_err_q;
    assign bus_io.if_rdata = if_rdata_q;
    assign bus_io.d_ack    = d_ack_q;
    assign bus_io.d_err    = d_err_q;
    assign bus_io.d_rdata  = d_rdata_q;
    assign bus_io.m_addr   = m_addr_q;
    assign bus_io.m_re     = m_re_q;
    assign bus_io.m_we     = m_we_q;
    assign bus_io.m_wdata  = m_wdata_q;
    assign bus_io.busy     = state_q != IDLE;
    always_comb begin
        gnt_d       = bus_io.d_req && (!bus_io.if_req || !hist_q);
        wr_d        = gnt_d && bus_io.d_we;
        addr_d      = gnt_d ? bus_io.d_addr : bus_io.if_addr;
        size_ok_d   = bus_io.d_size inside {3'b100, 3'b010, 3'b001};
        nb_d        = !gnt_d ? 3'd4 : size_ok_d ? bus_io.d_size : 3'd1;
        // One extra bit so an address wrap past 2^ADDR_W still reads as out of range
        last_d      = {1'b0, addr_d} + (ADDR_W+1)'(nb_d) - (ADDR_W+1)'(1);
        err_d       = (gnt_d && !size_ok_d) || last_d >= (ADDR_W+1)'(MEM_BYTES);
        buf_d       = buf_q;
        if (!we_q) buf_d[{beat_q, 3'b000} +: 8] = bus_io.m_rdata;
        ext_d       = !uns_q && (nb_q == 3'd2 ? buf_d[15] : buf_d[7]);
        rdata_d     = we_q ? '0 : nb_q == 3'd4 ? buf_d :
                      nb_q == 3'd2 ? {{16{ext_d}}, buf_d[15:0]} : {{24{ext_d}}, buf_d[7:0]};
        beat_d      = beat_q + 2'd1;
        last_beat_d = {1'b0, beat_q} == nb_q - 3'd1;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            hist_q     <= 1'b0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            nb_q       <= '0;
            beat_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= '0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
            m_addr_q   <= '0;
            m_re_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus_io.if_req || bus_io.d_req) begin
                    owner_q <= gnt_d;
                    hist_q  <= gnt_d;
                    addr_q  <= addr_d;
                    nb_q    <= nb_d;
                    we_q    <= wr_d;
                    uns_q   <= bus_io.d_unsigned;
                    wdata_q <= gnt_d ? bus_io.d_wdata : '0;
                    beat_q  <= '0;
                    buf_q   <= '0;
                    if (err_d) begin
                        state_q  <= RESP;
                        if_ack_q <= !gnt_d;
                        if_err_q <= !gnt_d;
                        d_ack_q  <= gnt_d;
                        d_err_q  <= gnt_d;
                    end else begin
                        state_q   <= XFER;
                        m_addr_q  <= addr_d;
                        m_re_q    <= !wr_d;
                        m_we_q    <= wr_d;
                        m_wdata_q <= wr_d ? bus_io.d_wdata[7:0] : '0;
                    end
                end
                XFER: begin
                    buf_q <= buf_d;
                    if (last_beat_d) begin
                        state_q    <= RESP;
                        m_addr_q   <= '0;
                        m_re_q     <= 1'b0;
                        m_we_q     <= 1'b0;
                        m_wdata_q  <= '0;
                        if_ack_q   <= !owner_q;
                        d_ack_q    <= owner_q;
                        if_rdata_q <= owner_q ? '0 : rdata_d;
                        d_rdata_q  <= owner_q ? rdata_d : '0;
                    end else begin
                        beat_q    <= beat_d;
                        m_addr_q  <= addr_q + ADDR_W'(beat_d);
                        m_wdata_q <= we_q ? wdata_q[{beat_d, 3'b000} +: 8] : '0;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    if_ack_q   <= 1'b0;
                    if_err_q   <= 1'b0;
                    if_rdata_q <= '0;
                    d_ack_q    <= 1'b0;
                    d_err_q    <= 1'b0;
                    d_rdata_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: directed scoreboard bench with a 16-byte memory model
module tb_mem_access_sequencer;
    typedef struct {bit dport; logic [31:0] rdata; logic err;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] mem [16] = '{default: 8'h00};
    exp_t sb[$];
    logic [15:0] wlog[$];
    int n_checks = 0;
    int n_fail = 0;
    int beats = 0;
    mem_access_sequencer_if #(.ADDR_W(32)) bus ();
    mem_access_sequencer #(.MEM_BYTES(16), .ADDR_W(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus));
    always #5 clk = ~clk;
    assign bus.m_rdata = (bus.m_addr < 32'd16) ? mem[bus.m_addr[3:0]] : 8'h00;
    always @(posedge clk) if (bus.m_we && bus.m_addr < 32'd16) mem[bus.m_addr[3:0]] <= bus.m_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.if_ack || bus.d_ack) begin
            if (sb.size() == 0) check("spurious_ack", 64'({bus.if_ack, bus.d_ack}), 64'(0));
            else begin
                e = sb.pop_front();
                check("ack_port", 64'({bus.d_ack, bus.if_ack}), e.dport ? 64'(2) : 64'(1));
                check("rdata", 64'(e.dport ? bus.d_rdata : bus.if_rdata), 64'(e.rdata));
                check("err", 64'(e.dport ? bus.d_err : bus.if_err), 64'(e.err));
                check("other_port_zero", e.dport ? 64'({bus.if_err, bus.if_rdata}) : 64'({bus.d_err, bus.d_rdata}), 64'(0));
            end
        end
    end

    always @(negedge clk) begin
        if (bus.m_we) wlog.push_back({bus.m_addr[7:0], bus.m_wdata});
        if (bus.m_re || bus.m_we) beats++;
        if (bus.m_re && bus.m_we) check("re_we_exclusive", 64'(1), 64'(0));
        if (!bus.m_re && !bus.m_we) check("mem_idle_zero", 64'({bus.m_addr, bus.m_wdata}), 64'(0));
    end

    task automatic wait_ack(input bit dport, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(dport ? bus.d_ack : bus.if_ack) && cyc < 40);
        if (!(dport ? bus.d_ack : bus.if_ack)) check("ack_timeout", 64'(0), 64'(1));
        if (dport) bus.d_req = 1'b0;
        else bus.if_req = 1'b0;
    endtask

    task automatic dreq(input bit we, input logic [2:0] sz, input bit un, input logic [31:0] a, input logic [31:0] wd);
        bus.d_we = we;
        bus.d_size = sz;
        bus.d_unsigned = un;
        bus.d_addr = a;
        bus.d_wdata = wd;
        bus.d_req = 1'b1;
    endtask

    task automatic dtxn(input bit we, input logic [2:0] sz, input bit un, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] erd, input bit eerr, input int lat);
        int c;
        sb.push_back('{1'b1, erd, eerr});
        dreq(we, sz, un, a, wd);
        wait_ack(1'b1, c);
        check("d_latency", 64'(c + 1), 64'(lat));
        @(posedge clk);
        #1;
    endtask

    task automatic ftxn(input logic [31:0] a, input logic [31:0] erd, input bit eerr, input int lat);
        int c;
        sb.push_back('{1'b0, erd, eerr});
        bus.if_addr = a;
        bus.if_req = 1'b1;
        wait_ack(1'b0, c);
        check("if_latency", 64'(c + 1), 64'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        dreq(1'b0, 3'b100, 1'b0, '0, '0);
        bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bus.if_ack, bus.if_err, bus.d_ack, bus.d_err, bus.m_re, bus.m_we, bus.busy}), 64'(0));
        check("reset_rdata", {bus.if_rdata, bus.d_rdata}, 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        dtxn(1'b1, 3'b100, 1'b0, 32'd0, 32'h0502_0304, 32'h0, 1'b0, 6);
        wlog.delete();
        dtxn(1'b1, 3'b100, 1'b0, 32'd4, 32'hA1B2_C3D4, 32'h0, 1'b0, 6);
        check("store_beats", 64'(wlog.size()), 64'(4));
        check("store_bytes", {wlog[0], wlog[1], wlog[2], wlog[3]}, 64'h04D4_05C3_06B2_07A1);
        ftxn(32'd0, 32'h0502_0304, 1'b0, 6);
        dtxn(1'b0, 3'b010, 1'b0, 32'd6, '0, 32'hFFFF_A1B2, 1'b0, 4);
        dtxn(1'b0, 3'b010, 1'b1, 32'd6, '0, 32'h0000_A1B2, 1'b0, 4);
        dtxn(1'b0, 3'b001, 1'b0, 32'd4, '0, 32'hFFFF_FFD4, 1'b0, 3);
        dtxn(1'b0, 3'b001, 1'b1, 32'd5, '0, 32'h0000_00C3, 1'b0, 3);
        dtxn(1'b0, 3'b001, 1'b0, 32'd0, '0, 32'h0000_0004, 1'b0, 3);
        dtxn(1'b0, 3'b100, 1'b0, 32'd3, '0, 32'hB2C3_D405, 1'b0, 6);
        dtxn(1'b0, 3'b010, 1'b0, 32'd14, '0, 32'h0000_0000, 1'b0, 4);
        b0 = beats;
        wlog.delete();
        dtxn(1'b1, 3'b100, 1'b0, 32'd14, 32'hDEAD_BEEF, 32'h0, 1'b1, 2);
        dtxn(1'b0, 3'b011, 1'b0, 32'd0, '0, 32'h0, 1'b1, 2);
        dtxn(1'b0, 3'b010, 1'b0, 32'd15, '0, 32'h0, 1'b1, 2);
        dtxn(1'b0, 3'b100, 1'b0, 32'hFFFF_FFFE, '0, 32'h0, 1'b1, 2);
        ftxn(32'd13, 32'h0, 1'b1, 2);
        check("error_no_beats", 64'(beats - b0), 64'(0));
        check("error_no_writes", 64'(wlog.size()), 64'(0));
        sb.push_back('{1'b1, 32'hA1B2_C3D4, 1'b0});
        sb.push_back('{1'b0, 32'h0502_0304, 1'b0});
        sb.push_back('{1'b1, 32'hA1B2_C3D4, 1'b0});
        sb.push_back('{1'b0, 32'h0502_0304, 1'b0});
        fork
            for (int k = 0; k < 2; k++) begin
                int c;
                dreq(1'b0, 3'b100, 1'b0, 32'd4, '0);
                wait_ack(1'b1, c);
                @(posedge clk);
                #1;
            end
            for (int j = 0; j < 2; j++) begin
                int c;
                bus.if_addr = 32'd0;
                bus.if_req = 1'b1;
                wait_ack(1'b0, c);
                @(posedge clk);
                #1;
            end
        join
        check("arb_all_acked", 64'(sb.size()), 64'(0));
        dreq(1'b1, 3'b100, 1'b0, 32'd8, 32'h1122_3344);
        repeat (3) @(posedge clk);
        #1;
        check("beat2_addr", 64'({bus.m_we, bus.m_addr}), {31'd0, 1'b1, 32'd10});
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'({bus.d_ack, bus.d_err, bus.m_re, bus.m_we, bus.busy, bus.m_wdata}), 64'(0));
        check("abort_addr", 64'(bus.m_addr), 64'(0));
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_mem", 64'({mem[8], mem[9], mem[10], mem[11]}), 64'h4433_0000);
        @(negedge clk);
        dtxn(1'b0, 3'b100, 1'b0, 32'd8, '0, 32'h0000_3344, 1'b0, 6);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
